mult_sched: RTL and testbench

- Shares one fully pipelined array multiplier (one operand pair accepted per clock, fixed latency, no reset, no valid signal) between NREQ requesters.
- Round-robin arbitration issues at most one operation per cycle.
- Tracks each in-flight operation's requester ID alongside the multiplier pipeline.
- Returns products in issue order through a credit-protected output FIFO with a valid/ready handshake.

---
 rtl/mult_sched.sv | 157 +++++++++++++++
 tb/tb_mult_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler that shares one pipelined multiplier between NREQ requesters.
// Products return in issue order through a credit-protected FIFO; define MULT_SCHED_PERF_EN for perf counters.
module mult_sched #(
    parameter int WIDTH      = 32,
    parameter int NREQ       = 4,
    parameter int MUL_LAT    = 33,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic [ID_W-1:0]         rsp_id
`ifdef MULT_SCHED_PERF_EN
    ,
    input  logic                    perf_clr,
    output logic [31:0]             perf_issued,
    output logic [31:0]             perf_stall
`endif
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant;
    logic               found;
    logic               issue;
    logic               push;
    logic               pop;
    logic [CW-1:0]      credit;
    logic [WIDTH-1:0]   last_a;
    logic [WIDTH-1:0]   last_b;

    logic [MUL_LAT-1:0] tag_v;
    logic [ID_W-1:0]    tag_id [MUL_LAT];

    logic [2*WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]    mem_id   [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;

    // First asserted request at or after the pointer wins, wrapping modulo NREQ.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    assign issue     = found && (credit != '0);
    assign req_ready = issue ? (NREQ'(1) << grant) : '0;
    assign mul_a     = issue ? req_a[int'(grant)*WIDTH +: WIDTH] : last_a;
    assign mul_b     = issue ? req_b[int'(grant)*WIDTH +: WIDTH] : last_b;

    assign push      = tag_v[MUL_LAT-1];
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = mem_data[rd_ptr];
    assign rsp_id    = mem_id[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            last_a <= '0;
            last_b <= '0;
        end else if (issue) begin
            rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
            last_a <= mul_a;
            last_b <= mul_b;
        end
    end

    // Credit covers both in-flight operations and FIFO occupancy, so the FIFO cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= CW'(FIFO_DEPTH);
        end else begin
            case ({issue, pop})
                2'b10:   credit <= credit - 1'b1;
                2'b01:   credit <= credit + 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= issue;
            for (int k = 1; k < MUL_LAT; k++) tag_v[k] <= tag_v[k-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= grant;
        for (int k = 1; k < MUL_LAT; k++) tag_id[k] <= tag_id[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_data[k] <= '0;
                mem_id[k]   <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= mul_y;
                mem_id[wr_ptr]   <= tag_id[MUL_LAT-1];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef MULT_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (perf_clr) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue && (perf_issued != '1)) perf_issued <= perf_issued + 1'b1;
            if ((|req_valid) && (credit == '0) && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: pipelined multiplier model plus a queue-based reference of issue order and credit.
module tb_mult_sched;
    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 33;
    localparam int DEPTH   = 8;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_y;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*WIDTH-1:0]    rsp_data;
    logic [ID_W-1:0]       rsp_id;
`ifdef MULT_SCHED_PERF_EN
    logic                  perf_clr;
    logic [31:0]           perf_issued;
    logic [31:0]           perf_stall;
`endif

    mult_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef MULT_SCHED_PERF_EN
        , .perf_clr(perf_clr), .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier: samples operands every edge, product appears MUL_LAT edges later.
    logic [2*WIDTH-1:0] pipe [MUL_LAT];
    always @(posedge clk) begin
        pipe[0] <= {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
        for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_y = pipe[MUL_LAT-1];

    typedef struct {
        logic [ID_W-1:0]    id;
        logic [2*WIDTH-1:0] prod;
        int                 c;
    } op_t;

    op_t              q[$];
    int               ptr = 0;
    logic [WIDTH-1:0] m_last_a = '0;
    logic [WIDTH-1:0] m_last_b = '0;
    int               cyc = 0;
    int               obs = 0;
    int               m_stall = 0;
    int               m_issued = 0;
    int               total = 0;
    int               bad = 0;
    int               first_rsp = -1;
    int               rsp_cnt = 0;
    int               hs_cnt = 0;
    logic [NREQ-1:0]  last_ready = '0;
    logic [2*WIDTH-1:0] first_data = '0;
    logic [2*WIDTH-1:0] last_pop_data [NREQ];

    function automatic void check(string tag, logic [127:0] o, logic [127:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        ptr      = 0;
        m_last_a = '0;
        m_last_b = '0;
        obs      = 0;
        m_stall  = 0;
        m_issued = 0;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            req_a[i*WIDTH +: WIDTH] = (sel == 0) ? '0 : (sel == 1) ? '1 : $urandom;
            req_b[i*WIDTH +: WIDTH] = (sel == 2) ? '1 : $urandom;
        end
    endtask

    // One clock: sample 1 ns before the rising edge, compare with the model, advance to the falling edge.
    task automatic tick();
        logic [NREQ-1:0] er;
        logic            found;
        logic            exp_v;
        int              w;
        op_t             op;
        #4;
        er = '0;
        found = 1'b0;
        w = 0;
        if (rst_n && (q.size() < DEPTH)) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr + k) % NREQ;
                if (!found && req_valid[i]) begin
                    found = 1'b1;
                    w = i;
                end
            end
        end
        if (found) er[w] = 1'b1;
        if (rst_n && (|req_valid) && (q.size() == DEPTH)) m_stall++;
        check("req_ready", req_ready, er);
        last_ready = req_ready;
        if (found) begin
            check("mul_a_issue", mul_a, req_a[w*WIDTH +: WIDTH]);
            check("mul_b_issue", mul_b, req_b[w*WIDTH +: WIDTH]);
            op.id   = ID_W'(w);
            op.prod = {{WIDTH{1'b0}}, req_a[w*WIDTH +: WIDTH]} * {{WIDTH{1'b0}}, req_b[w*WIDTH +: WIDTH]};
            op.c    = cyc;
            m_last_a = req_a[w*WIDTH +: WIDTH];
            m_last_b = req_b[w*WIDTH +: WIDTH];
            ptr = (w + 1) % NREQ;
            m_issued++;
        end else begin
            check("mul_a_hold", mul_a, m_last_a);
            check("mul_b_hold", mul_b, m_last_b);
        end
        exp_v = rst_n && (q.size() > 0) && ((cyc - q[0].c) >= MUL_LAT + 1);
        check("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
            check("rsp_data", rsp_data, q[0].prod);
            check("rsp_id", rsp_id, q[0].id);
        end
        if (rsp_valid) begin
            rsp_cnt++;
            if (first_rsp < 0) begin
                first_rsp  = cyc;
                first_data = rsp_data;
            end
            if (rsp_ready) begin
                last_pop_data[rsp_id] = rsp_data;
                obs--;
            end
        end
        if (exp_v && rsp_ready) void'(q.pop_front());
        if (found) q.push_back(op);
        if (|(req_valid & req_ready)) begin
            obs++;
            hs_cnt++;
        end
        check("outstanding_le_depth", (obs <= DEPTH), 1'b1);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int issue_cyc;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
`ifdef MULT_SCHED_PERF_EN
        perf_clr  = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) last_pop_data[i] = '0;

        // Reset state
        tick();
        check("rst_rsp_data", rsp_data, '0);
        check("rst_rsp_id", rsp_id, '0);
        tick();
        rst_n = 1'b1;

        // Single operation from requester 2
        req_a[2*WIDTH +: WIDTH] = 32'd7;
        req_b[2*WIDTH +: WIDTH] = 32'd9;
        req_valid = 4'b0100;
        issue_cyc = cyc;
        first_rsp = -1;
        rsp_cnt = 0;
        tick();
        check("single_grant", last_ready, 4'b0100);
        req_valid = '0;
        repeat (MUL_LAT + 6) tick();
        check("single_latency", first_rsp - issue_cyc, MUL_LAT + 1);
        check("single_data", first_data, 64'd63);
        check("single_once", rsp_cnt, 1);

        // Round robin with all requesters active
        req_valid = '1;
        repeat (80) begin
            rand_ops();
            tick();
        end

        // Backpressure: only DEPTH operations may be outstanding
        req_valid = '0;
        repeat (MUL_LAT + 12) tick();
        rsp_ready = 1'b0;
        req_valid = '1;
        hs_cnt = 0;
        repeat (MUL_LAT + 15) begin
            rand_ops();
            tick();
        end
        check("bp_issue_count", hs_cnt, DEPTH);
        check("bp_ready_zero", req_ready, '0);
        check("bp_rsp_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        repeat (80) begin
            rand_ops();
            tick();
        end

        // Operand extremes
        req_valid = '0;
        repeat (MUL_LAT + 12) tick();
        req_a[1*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        req_b[1*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        req_a[3*WIDTH +: WIDTH] = 32'h0;
        req_b[3*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        repeat (MUL_LAT + 6) tick();
        check("ext_max", last_pop_data[1], 64'hFFFF_FFFE_0000_0001);
        check("ext_zero", last_pop_data[3], 64'h0);

        // Reset while operations are in flight
        req_valid = '1;
        repeat (3) begin
            rand_ops();
            tick();
        end
        rst_n = 1'b0;
        req_valid = '0;
        model_reset();
        tick();
        rst_n = 1'b1;
        rsp_cnt = 0;
        repeat (MUL_LAT + 8) tick();
        check("rst_no_rsp", rsp_cnt, 0);
        rsp_ready = 1'b0;
        req_valid = '1;
        hs_cnt = 0;
        rand_ops();
        tick();
        check("rst_grant0", last_ready, 4'b0001);
        repeat (MUL_LAT + 12) begin
            rand_ops();
            tick();
        end
        check("rst_credit_full", hs_cnt, DEPTH);

        // Full FIFO with rsp_ready toggling each cycle
        repeat (200) begin
            rsp_ready = ~rsp_ready;
            rand_ops();
            tick();
        end

        // Fully random traffic
        repeat (300) begin
            req_valid = NREQ'($urandom);
            rsp_ready = 1'($urandom);
            rand_ops();
            tick();
        end

        // Drain
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (MUL_LAT + 20) tick();
        check("drain_empty", rsp_valid, 1'b0);
`ifdef MULT_SCHED_PERF_EN
        check("perf_issued", perf_issued, m_issued);
        check("perf_stall", perf_stall, m_stall);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        check("perf_clr_issued", perf_issued, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
